immediate_gen_stage: RTL and testbench

Registered, parametrised immediate-generation stage for the decode pipeline. Accepts a fetched instruction and its PC, and presents the following to the execute stage one cycle later behind a valid/ready handshake:
- the sign- or zero-extended immediate, XLEN bits wide;
- its format tag;
- the PC-relative target (PC + immediate).

It supports RV32 and RV64 via XLEN, decodes shift-amount and CSR-uimm forms, and provides an optional skid buffer for full throughput under backpressure.

---
 rtl/defaultParametersPkg.sv | 28 ++
 rtl/immediate_extract.sv | 102 ++++++++++
 rtl/immediate_gen_stage.sv | 98 +++++++++
 tb/tb_immediate_gen_stage.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/defaultParametersPkg.sv
// Shared decode-pipeline parameters: opcode constants
// and the immediate format tag.
package defaultParametersPkg;

    localparam logic [6:0] IType       = 7'b0010011;
    localparam logic [6:0] ITypeLoad   = 7'b0000011;
    localparam logic [6:0] ITypeJALR   = 7'b1100111;
    localparam logic [6:0] SType       = 7'b0100011;
    localparam logic [6:0] BType       = 7'b1100011;
    localparam logic [6:0] UType       = 7'b0110111;
    localparam logic [6:0] UTypeLUI    = 7'b0110111;
    localparam logic [6:0] UTypeAUIPC  = 7'b0010111;
    localparam logic [6:0] JType       = 7'b1101111;
    localparam logic [6:0] OpImm32Type = 7'b0011011;
    localparam logic [6:0] SystemType  = 7'b1110011;

    typedef enum logic [3:0] {
        IMM_NONE    = 4'd0,
        IMM_I       = 4'd1,
        IMM_S       = 4'd2,
        IMM_B       = 4'd3,
        IMM_U       = 4'd4,
        IMM_J       = 4'd5,
        IMM_SHAMT   = 4'd6,
        IMM_CSRUIMM = 4'd7
    } immFormat_t;

endpackage

// File: rtl/immediate_extract.sv
// Combinational immediate extraction: picks the immediate
// form from the opcode and extends it to XLEN bits.
module immediate_extract
    import defaultParametersPkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output immFormat_t      fmt_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        sgn;
    logic        isShift;
    logic [63:0] iImm;
    logic [63:0] sImm;
    logic [63:0] bImm;
    logic [63:0] uImm;
    logic [63:0] jImm;
    logic [63:0] shImm;
    logic [63:0] shwImm;
    logic [63:0] csrImm;
    logic [63:0] wide;

    assign opcode  = instr_i[6:0];
    assign funct3  = instr_i[14:12];
    assign sgn     = instr_i[31];
    assign isShift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // All forms are built 64 bits wide and narrowed to XLEN at the end.
    assign iImm   = {{52{sgn}}, instr_i[31:20]};
    assign sImm   = {{52{sgn}}, instr_i[31:25], instr_i[11:7]};
    assign bImm   = {{51{sgn}}, instr_i[31], instr_i[7],
                     instr_i[30:25], instr_i[11:8], 1'b0};
    assign uImm   = {{32{sgn}}, instr_i[31:12], 12'b0};
    assign jImm   = {{43{sgn}}, instr_i[31], instr_i[19:12],
                     instr_i[20], instr_i[30:21], 1'b0};
    assign shImm  = (XLEN == 64) ? {58'b0, instr_i[25:20]}
                                 : {59'b0, instr_i[24:20]};
    assign shwImm = {59'b0, instr_i[24:20]};
    assign csrImm = {59'b0, instr_i[19:15]};

    // Select immediate and tag by opcode; anything unrecognised is NONE/0.
    always_comb begin
        wide  = '0;
        fmt_o = IMM_NONE;
        case (opcode)
            IType: begin
                if (isShift) begin
                    fmt_o = IMM_SHAMT;
                    wide  = shImm;
                end else begin
                    fmt_o = IMM_I;
                    wide  = iImm;
                end
            end
            ITypeLoad, ITypeJALR: begin
                fmt_o = IMM_I;
                wide  = iImm;
            end
            OpImm32Type: begin
                if (XLEN == 64) begin
                    if (funct3 == 3'b000) begin
                        fmt_o = IMM_I;
                        wide  = iImm;
                    end else if (isShift) begin
                        fmt_o = IMM_SHAMT;
                        wide  = shwImm;
                    end
                end
            end
            SType: begin
                fmt_o = IMM_S;
                wide  = sImm;
            end
            BType: begin
                fmt_o = IMM_B;
                wide  = bImm;
            end
            UTypeLUI, UTypeAUIPC: begin
                fmt_o = IMM_U;
                wide  = uImm;
            end
            JType: begin
                fmt_o = IMM_J;
                wide  = jImm;
            end
            SystemType: begin
                if (funct3[2]) begin
                    fmt_o = IMM_CSRUIMM;
                    wide  = csrImm;
                end
            end
            default: ;
        endcase
    end

    assign imm_o = XLEN'(wide);

endmodule

// File: rtl/immediate_gen_stage.sv
// Registered immediate-generation stage with valid/ready
// handshake and optional two-entry skid buffer.
module immediate_gen_stage
    import defaultParametersPkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit SKID_ENABLE = 1'b1
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            flush,
    input  logic            inValid,
    output logic            inReady,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] immediateValue,
    output immFormat_t      immFormat,
    output logic [XLEN-1:0] targetAddress,
    output logic [XLEN-1:0] pcOut
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        immFormat_t      fmt;
        logic [XLEN-1:0] tgt;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0] extImm;
    immFormat_t      extFmt;
    entry_t          new_d;
    entry_t          out_q;
    entry_t          skid_q;
    logic            outValid_q;
    logic            skidValid_q;
    logic            inXfer;
    logic            outFree;

    immediate_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .instr_i (instruction),
        .imm_o   (extImm),
        .fmt_o   (extFmt)
    );

    // Build the candidate entry, including the PC-relative target.
    always_comb begin
        new_d.imm = extImm;
        new_d.fmt = extFmt;
        new_d.tgt = pc + extImm;
        new_d.pc  = pc;
    end

    // Skid mode accepts whenever the skid slot is free; plain mode
    // accepts only when the output slot is empty or draining.
    assign inReady = SKID_ENABLE ? !skidValid_q
                                 : (!outValid_q || outReady);
    assign inXfer  = inValid && inReady;
    assign outFree = !outValid_q || outReady;

    // Output/skid occupancy: drain skid first, else load new entry;
    // a stalled output parks a new entry in the skid slot.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            outValid_q  <= 1'b0;
            skidValid_q <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else if (flush) begin
            outValid_q  <= 1'b0;
            skidValid_q <= 1'b0;
        end else if (outFree) begin
            if (skidValid_q) begin
                out_q       <= skid_q;
                outValid_q  <= 1'b1;
                skidValid_q <= 1'b0;
            end else if (inXfer) begin
                out_q      <= new_d;
                outValid_q <= 1'b1;
            end else begin
                outValid_q <= 1'b0;
            end
        end else if (inXfer) begin
            skid_q      <= new_d;
            skidValid_q <= 1'b1;
        end
    end

    assign outValid       = outValid_q;
    assign immediateValue = out_q.imm;
    assign immFormat      = out_q.fmt;
    assign targetAddress  = out_q.tgt;
    assign pcOut          = out_q.pc;

endmodule

// File: tb/tb_immediate_gen_stage.sv
// Bench for immediate_gen_stage: RV32/RV64 skid instances
// and an RV32 single-register instance on a shared stream.
module tb_immediate_gen_stage;
    import defaultParametersPkg::*;

    typedef struct packed {
        logic [63:0] imm;
        immFormat_t  fmt;
        logic [63:0] tgt;
        logic [63:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        flush = 1'b0;
    logic        inValid = 1'b0;
    logic        outReady = 1'b0;
    logic [31:0] instruction = '0;
    logic [63:0] pc = '0;

    logic        ir [3];
    logic        ov [3];
    logic [63:0] imm [3];
    immFormat_t  fmt [3];
    logic [63:0] tgt [3];
    logic [63:0] pco [3];

    logic [31:0] imm_a, tgt_a, pco_a, imm_c, tgt_c, pco_c;
    logic [63:0] imm_b, tgt_b, pco_b;

    int   checks = 0;
    int   fails = 0;
    int   delivered [3] = '{0, 0, 0};
    exp_t sb [3][$];

    always #5 clk = ~clk;

    immediate_gen_stage #(.XLEN(32), .SKID_ENABLE(1'b1)) dut_a (
        .clk(clk), .resetN(resetN), .flush(flush),
        .inValid(inValid), .inReady(ir[0]),
        .instruction(instruction), .pc(pc[31:0]),
        .outValid(ov[0]), .outReady(outReady),
        .immediateValue(imm_a), .immFormat(fmt[0]),
        .targetAddress(tgt_a), .pcOut(pco_a));

    immediate_gen_stage #(.XLEN(64), .SKID_ENABLE(1'b1)) dut_b (
        .clk(clk), .resetN(resetN), .flush(flush),
        .inValid(inValid), .inReady(ir[1]),
        .instruction(instruction), .pc(pc),
        .outValid(ov[1]), .outReady(outReady),
        .immediateValue(imm_b), .immFormat(fmt[1]),
        .targetAddress(tgt_b), .pcOut(pco_b));

    immediate_gen_stage #(.XLEN(32), .SKID_ENABLE(1'b0)) dut_c (
        .clk(clk), .resetN(resetN), .flush(flush),
        .inValid(inValid), .inReady(ir[2]),
        .instruction(instruction), .pc(pc[31:0]),
        .outValid(ov[2]), .outReady(outReady),
        .immediateValue(imm_c), .immFormat(fmt[2]),
        .targetAddress(tgt_c), .pcOut(pco_c));

    assign imm[0] = {32'b0, imm_a};
    assign tgt[0] = {32'b0, tgt_a};
    assign pco[0] = {32'b0, pco_a};
    assign imm[1] = imm_b;
    assign tgt[1] = tgt_b;
    assign pco[1] = pco_b;
    assign imm[2] = {32'b0, imm_c};
    assign tgt[2] = {32'b0, tgt_c};
    assign pco[2] = {32'b0, pco_c};

    // Reference decode using signed arithmetic on the instruction word.
    function automatic exp_t ref_model(input logic [31:0] ins,
                                       input logic [63:0] p,
                                       input int xlen);
        exp_t        e;
        int          si;
        longint      s;
        longint      v;
        logic [63:0] r;
        logic [2:0]  f3;
        logic        sh;
        si = ins;
        s  = longint'(si);
        f3 = ins[14:12];
        sh = (f3 == 3'b001) || (f3 == 3'b101);
        v  = 0;
        e.fmt = IMM_NONE;
        case (ins[6:0])
            7'b0010011: begin
                if (sh) begin
                    e.fmt = IMM_SHAMT;
                    v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
                end else begin
                    e.fmt = IMM_I;
                    v = s >>> 20;
                end
            end
            7'b0000011, 7'b1100111: begin
                e.fmt = IMM_I;
                v = s >>> 20;
            end
            7'b0011011: begin
                if (xlen == 64 && f3 == 3'b000) begin
                    e.fmt = IMM_I;
                    v = s >>> 20;
                end else if (xlen == 64 && sh) begin
                    e.fmt = IMM_SHAMT;
                    v = longint'(ins[24:20]);
                end
            end
            7'b0100011: begin
                e.fmt = IMM_S;
                v = (s >>> 25) * 32 + longint'(ins[11:7]);
            end
            7'b1100011: begin
                e.fmt = IMM_B;
                v = (s >>> 31) * 4096 + longint'(ins[7]) * 2048
                  + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            end
            7'b0110111, 7'b0010111: begin
                e.fmt = IMM_U;
                v = (s >>> 12) * 4096;
            end
            7'b1101111: begin
                e.fmt = IMM_J;
                v = (s >>> 31) * 1048576 + longint'(ins[19:12]) * 4096
                  + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            end
            7'b1110011: begin
                if (f3[2]) begin
                    e.fmt = IMM_CSRUIMM;
                    v = longint'(ins[19:15]);
                end
            end
            default: ;
        endcase
        r = v;
        if (xlen == 32) r[63:32] = '0;
        e.imm = r;
        e.pc  = (xlen == 32) ? {32'b0, p[31:0]} : p;
        e.tgt = e.pc + r;
        if (xlen == 32) e.tgt[63:32] = '0;
        return e;
    endfunction

    // Expected inReady from model occupancy.
    function automatic logic exp_ready(input int k);
        if (k == 2) return (sb[k].size() == 0) || outReady;
        return sb[k].size() < 2;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11];
        logic [31:0] r;
        int          idx;
        ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011,
                7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                7'b1101111, 7'b1110011, 7'b0110011};
        r   = $urandom;
        idx = $urandom_range(0, 11);
        if (idx == 11) return r;
        return {r[31:7], ops[idx]};
    endfunction

    // One clock: model acceptance/drain, then return at the negedge.
    task automatic tick(output bit acc0);
        bit   acc [3];
        bit   drn [3];
        exp_t e32;
        exp_t e64;
        #1;
        for (int k = 0; k < 3; k++) begin
            acc[k] = inValid && exp_ready(k) && !flush;
            drn[k] = (sb[k].size() != 0) && outReady;
        end
        acc0 = acc[0];
        e32 = ref_model(instruction, pc, 32);
        e64 = ref_model(instruction, pc, 64);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (flush) begin
                sb[k].delete();
            end else begin
                if (drn[k]) begin
                    void'(sb[k].pop_front());
                    delivered[k]++;
                end
                if (acc[k]) sb[k].push_back(k == 1 ? e64 : e32);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b0) begin
                fails++;
                $display("FAIL reset_outValid[%0d] got %b want 0", k, ov[k]);
            end
            checks++;
            if (ir[k] !== 1'b1) begin
                fails++;
                $display("FAIL reset_inReady[%0d] got %b want 1", k, ir[k]);
            end
            checks++;
            if ({imm[k], fmt[k], tgt[k], pco[k]} !== '0) begin
                fails++;
                $display("FAIL reset_regs[%0d] got imm=%h fmt=%0d tgt=%h pc=%h want all 0",
                         k, imm[k], fmt[k], tgt[k], pco[k]);
            end
        end
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] ins [10];
        logic [63:0] pcs [10];
        logic [63:0] i32 [10];
        logic [63:0] i64 [10];
        logic [63:0] t32 [10];
        immFormat_t  f32 [10];
        immFormat_t  f64 [10];
        bit          a;
        ins = '{32'hFFF00093, 32'h800000B7, 32'h03F09093, 32'hFE000EE3,
                32'h0010006F, 32'h4000006F, 32'h00000073, 32'h000FD073,
                32'h0010009B, 32'h43F0D093};
        pcs = '{64'h0, 64'h0, 64'h0, 64'h100, 64'h100,
                64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
        i32 = '{64'hFFFFFFFF, 64'h80000000, 64'h1F, 64'hFFFFFFFC, 64'h800,
                64'h400, 64'h0, 64'h1F, 64'h0, 64'h1F};
        i64 = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 64'h3F,
                64'hFFFFFFFFFFFFFFFC, 64'h800, 64'h400, 64'h0, 64'h1F,
                64'h1, 64'h3F};
        t32 = '{64'hFFFFFFFF, 64'h80000000, 64'h1F, 64'hFC, 64'h900,
                64'h400, 64'h0, 64'h1F, 64'h0, 64'h1F};
        f32 = '{IMM_I, IMM_U, IMM_SHAMT, IMM_B, IMM_J,
                IMM_J, IMM_NONE, IMM_CSRUIMM, IMM_NONE, IMM_SHAMT};
        f64 = '{IMM_I, IMM_U, IMM_SHAMT, IMM_B, IMM_J,
                IMM_J, IMM_NONE, IMM_CSRUIMM, IMM_I, IMM_SHAMT};
        outReady = 1'b1;
        for (int n = 0; n < 10; n++) begin
            inValid = 1'b1;
            instruction = ins[n];
            pc = pcs[n];
            tick(a);
            checks++;
            if (ov[0] !== 1'b1 || imm[0] !== i32[n] || fmt[0] !== f32[n]
                || tgt[0] !== t32[n]) begin
                fails++;
                $display("FAIL dir32 %h got v=%b imm=%h fmt=%0d tgt=%h want imm=%h fmt=%0d tgt=%h",
                         ins[n], ov[0], imm[0], fmt[0], tgt[0], i32[n], f32[n], t32[n]);
            end
            checks++;
            if (ov[1] !== 1'b1 || imm[1] !== i64[n] || fmt[1] !== f64[n]) begin
                fails++;
                $display("FAIL dir64 %h got v=%b imm=%h fmt=%0d want imm=%h fmt=%0d",
                         ins[n], ov[1], imm[1], fmt[1], i64[n], f64[n]);
            end
        end
        inValid = 1'b0;
        tick(a);
    endtask

    task automatic test_random_stream();
        bit a;
        for (int n = 0; n < 400; n++) begin
            inValid = ($urandom_range(0, 3) != 0);
            outReady = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 31) == 0);
            instruction = rand_instr();
            pc = {$urandom, $urandom};
            tick(a);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ir[k] !== exp_ready(k) || ov[k] !== (sb[k].size() != 0)) begin
                    fails++;
                    $display("FAIL rand_hs[%0d] cyc %0d got rdy=%b v=%b want rdy=%b v=%b",
                             k, n, ir[k], ov[k], exp_ready(k), sb[k].size() != 0);
                end else if (sb[k].size() != 0) begin
                    checks++;
                    if ({imm[k], fmt[k], tgt[k], pco[k]} !== sb[k][0]) begin
                        fails++;
                        $display("FAIL rand_data[%0d] cyc %0d got %h/%0d/%h/%h want %h/%0d/%h/%h",
                                 k, n, imm[k], fmt[k], tgt[k], pco[k], sb[k][0].imm,
                                 sb[k][0].fmt, sb[k][0].tgt, sb[k][0].pc);
                    end
                end
            end
        end
        flush = 1'b0;
        inValid = 1'b0;
        outReady = 1'b1;
        tick(a);
        tick(a);
        tick(a);
    endtask

    task automatic test_back_to_back();
        int base0;
        int base1;
        int sent;
        bit a;
        base0 = delivered[0];
        base1 = delivered[1];
        sent = 0;
        for (int n = 0; n < 8; n++) begin
            inValid = (sent < 4);
            outReady = (n != 2);
            instruction = {20'h00100 + 20'(sent), 12'h093};
            pc = 64'h1000 + 64'(4 * sent);
            tick(a);
            if (a) sent++;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (ir[k] !== exp_ready(k) || ov[k] !== (sb[k].size() != 0)) begin
                    fails++;
                    $display("FAIL b2b_hs[%0d] cyc %0d got rdy=%b v=%b want rdy=%b v=%b",
                             k, n, ir[k], ov[k], exp_ready(k), sb[k].size() != 0);
                end else if (sb[k].size() != 0) begin
                    checks++;
                    if ({imm[k], fmt[k], tgt[k], pco[k]} !== sb[k][0]) begin
                        fails++;
                        $display("FAIL b2b_data[%0d] cyc %0d got imm=%h pc=%h want imm=%h pc=%h",
                                 k, n, imm[k], pco[k], sb[k][0].imm, sb[k][0].pc);
                    end
                end
            end
            if (n == 2) begin
                checks++;
                if (ir[0] !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_skid_full got inReady=%b want 0", ir[0]);
                end
            end
        end
        checks++;
        if (delivered[0] - base0 != 4 || delivered[1] - base1 != 4) begin
            fails++;
            $display("FAIL b2b_count got %0d/%0d want 4/4",
                     delivered[0] - base0, delivered[1] - base1);
        end
        inValid = 1'b0;
        tick(a);
    endtask

    task automatic test_flush();
        bit a;
        inValid = 1'b1;
        outReady = 1'b0;
        for (int n = 0; n < 3; n++) begin
            instruction = rand_instr();
            pc = {$urandom, $urandom};
            tick(a);
        end
        checks++;
        if (ov[0] !== 1'b1 || ir[0] !== 1'b0) begin
            fails++;
            $display("FAIL flush_setup got v=%b rdy=%b want v=1 rdy=0", ov[0], ir[0]);
        end
        flush = 1'b1;
        tick(a);
        flush = 1'b0;
        inValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b0 || ir[k] !== 1'b1) begin
                fails++;
                $display("FAIL flush_full[%0d] got v=%b rdy=%b want v=0 rdy=1",
                         k, ov[k], ir[k]);
            end
        end
        outReady = 1'b1;
        inValid = 1'b1;
        instruction = 32'h00500093;
        tick(a);
        outReady = 1'b0;
        instruction = 32'h00700093;
        flush = 1'b1;
        tick(a);
        flush = 1'b0;
        inValid = 1'b0;
        outReady = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick(a);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ov[k] !== 1'b0 || ir[k] !== 1'b1) begin
                    fails++;
                    $display("FAIL flush_wins[%0d] cyc %0d got v=%b rdy=%b want v=0 rdy=1",
                             k, n, ov[k], ir[k]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        bit a;
        inValid = 1'b1;
        outReady = 1'b0;
        instruction = 32'h800000B7;
        tick(a);
        instruction = 32'hFE000EE3;
        tick(a);
        #2;
        resetN = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b0 || fmt[k] !== IMM_NONE || imm[k] !== '0) begin
                fails++;
                $display("FAIL async_reset[%0d] got v=%b fmt=%0d imm=%h want 0/NONE/0",
                         k, ov[k], fmt[k], imm[k]);
            end
            sb[k].delete();
        end
        @(negedge clk);
        resetN = 1'b1;
        inValid = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ir[k] !== 1'b1 || ov[k] !== 1'b0) begin
                fails++;
                $display("FAIL post_reset[%0d] got rdy=%b v=%b want rdy=1 v=0",
                         k, ir[k], ov[k]);
            end
        end
        inValid = 1'b1;
        outReady = 1'b1;
        instruction = 32'h00000073;
        tick(a);
        inValid = 1'b0;
        checks++;
        if (ov[0] !== 1'b1 || fmt[0] !== IMM_NONE || imm[0] !== '0) begin
            fails++;
            $display("FAIL ecall got v=%b fmt=%0d imm=%h want 1/NONE/0",
                     ov[0], fmt[0], imm[0]);
        end
        tick(a);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random_stream();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
